// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap sequencer.
// Also carries the dag config-word layout used by the host.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        XA,
        XM,
        HA,
        HM,
        MAC,
        DONE
    } tap_state_t;

    localparam int DW_DEF   = 16;
    localparam int AW_DEF   = 16;
    localparam int ACCW_DEF = 40;

    localparam logic [2:0] CBS_X = 3'd0;
    localparam logic [2:0] CBS_H = 3'd1;

    localparam int CFG_BASE_LSB = 16;
    localparam int CFG_BASE_W   = 16;
    localparam int CFG_LEN_LSB  = 4;
    localparam int CFG_LEN_W    = 12;
    localparam int CFG_SIGN_BIT = 3;
    localparam int CFG_EXP_LSB  = 0;
    localparam int CFG_EXP_W    = 3;

    // Packs a dag circular-buffer config word.
    function automatic logic [31:0] dag_cfg(
        input logic [15:0] base,
        input logic [11:0] len,
        input logic        sgn,
        input logic [2:0]  exp_s
    );
        logic [31:0] w;
        w = '0;
        w[CFG_BASE_LSB +: CFG_BASE_W] = base;
        w[CFG_LEN_LSB +: CFG_LEN_W]   = len;
        w[CFG_SIGN_BIT]               = sgn;
        w[CFG_EXP_LSB +: CFG_EXP_W]   = exp_s;
        return w;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed DW x DW multiply with wrapping ACCW accumulator.
// Clear has priority over accumulate.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] prod_ext;
    logic [ACCW-1:0]        acc_d;
    logic [ACCW-1:0]        acc_q;

    // Full-precision product, sign-extended, then added modulo 2^ACCW.
    always_comb begin
        prod     = $signed(a) * $signed(b);
        prod_ext = ACCW'(prod);
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACCW'(prod_ext);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_tap_seq.sv
// FIR tap sequencer: walks N taps through dag and data memory,
// accumulates x*h and presents y with a one-cycle strobe.
module fir_tap_seq
    import fir_pkg::*;
#(
    parameter int         DW   = DW_DEF,
    parameter int         AW   = AW_DEF,
    parameter int         ACCW = ACCW_DEF,
    parameter logic [2:0] XCBS = CBS_X,
    parameter logic [2:0] HCBS = CBS_H
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      taps,
    output logic            dag_re,
    output logic [2:0]      dag_cbs,
    input  logic [AW-1:0]   dag_a,
    output logic            mem_rd,
    output logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy,
    output logic [ACCW-1:0] y,
    output logic            y_valid
);

    tap_state_t      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [DW-1:0]   x_reg_q, x_reg_d;
    logic [ACCW-1:0] y_q, y_d;
    logic [ACCW-1:0] acc;
    logic            mac_clr;
    logic            mac_en;

    fir_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (x_reg_q),
        .b     (mem_rdata),
        .acc   (acc)
    );

    // Next-state and output decode from the registered state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_reg_d  = x_reg_q;
        y_d      = y_q;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        dag_re   = 1'b0;
        dag_cbs  = XCBS;
        mem_rd   = 1'b0;
        mem_addr = '0;
        busy     = 1'b0;
        y_valid  = 1'b0;
        y        = y_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mac_clr = 1'b1;
                    cnt_d   = taps;
                    y_d     = '0;
                    state_d = (taps == 8'd0) ? DONE : XA;
                end
            end
            XA: begin
                busy    = 1'b1;
                dag_re  = 1'b1;
                state_d = XM;
            end
            XM: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = dag_a;
                state_d  = HA;
            end
            HA: begin
                busy    = 1'b1;
                dag_re  = 1'b1;
                dag_cbs = HCBS;
                x_reg_d = mem_rdata;
                state_d = HM;
            end
            HM: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = dag_a;
                state_d  = MAC;
            end
            MAC: begin
                busy    = 1'b1;
                mac_en  = 1'b1;
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? DONE : XA;
            end
            DONE: begin
                y_valid = 1'b1;
                y       = acc;
                y_d     = acc;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, tap counter, sample latch and held result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_reg_q <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_reg_q <= x_reg_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_fir_tap_seq.sv
// Self-checking bench for fir_tap_seq with a behavioural dag
// and synchronous-read memory; a 32-bit instance checks wrap.
`timescale 1ns/1ps
module tb_fir_tap_seq;
    import fir_pkg::*;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int ACCW = 40;

    localparam logic [31:0] XCFG = dag_cfg(16'hAB00, 12'h008, 1'b0, 3'd1);
    localparam logic [31:0] HCFG = dag_cfg(16'hC000, 12'h008, 1'b0, 3'd1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      taps = 8'd0;
    logic            dag_re;
    logic [2:0]      dag_cbs;
    logic [AW-1:0]   dag_a;
    logic            mem_rd;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic [ACCW-1:0] y;
    logic            y_valid;

    logic            start2 = 1'b0;
    logic [7:0]      taps2 = 8'd0;
    logic            dag_re2;
    logic [2:0]      dag_cbs2;
    logic            mem_rd2;
    logic [AW-1:0]   mem_addr2;
    logic            busy2;
    logic [31:0]     y2;
    logic            y_valid2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_tap_seq #(.DW(DW), .AW(AW), .ACCW(ACCW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .taps      (taps),
        .dag_re    (dag_re),
        .dag_cbs   (dag_cbs),
        .dag_a     (dag_a),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .y         (y),
        .y_valid   (y_valid)
    );

    fir_tap_seq #(.DW(DW), .AW(AW), .ACCW(32)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .taps      (taps2),
        .dag_re    (dag_re2),
        .dag_cbs   (dag_cbs2),
        .dag_a     (16'h0000),
        .mem_rd    (mem_rd2),
        .mem_addr  (mem_addr2),
        .mem_rdata (16'h8000),
        .busy      (busy2),
        .y         (y2),
        .y_valid   (y_valid2)
    );

    // Behavioural dag: config write from host, post-increment on re.
    logic        dag_we = 1'b0;
    logic [2:0]  dag_wsel = 3'd0;
    logic [31:0] dag_wd = 32'd0;
    logic [15:0] d_base [2];
    logic [15:0] d_len  [2];
    logic [15:0] d_step [2];
    logic [15:0] d_ptr  [2];
    logic        d_dn   [2];
    logic        rsel, wsel;

    assign rsel = (dag_cbs == CBS_H);
    assign wsel = (dag_wsel == CBS_H);

    function automatic logic [15:0] next_ptr(
        input logic [15:0] base, input logic [15:0] ptr,
        input logic [15:0] len, input logic [15:0] step,
        input logic dn);
        int off;
        off = int'(ptr - base);
        if (dn) off = (off + int'(len) - int'(step)) % int'(len);
        else    off = (off + int'(step)) % int'(len);
        return base + 16'(off);
    endfunction

    always @(posedge clk) begin
        if (dag_we) begin
            d_base[wsel] <= dag_wd[CFG_BASE_LSB +: 16];
            d_ptr[wsel]  <= dag_wd[CFG_BASE_LSB +: 16];
            d_len[wsel]  <= 16'(dag_wd[CFG_LEN_LSB +: 12]);
            d_step[wsel] <= 16'd1 << dag_wd[CFG_EXP_LSB +: 3];
            d_dn[wsel]   <= dag_wd[CFG_SIGN_BIT];
        end else if (dag_re) begin
            dag_a <= d_ptr[rsel];
            d_ptr[rsel] <= next_ptr(d_base[rsel], d_ptr[rsel],
                                    d_len[rsel], d_step[rsel], d_dn[rsel]);
        end
    end

    logic [15:0] mem [0:65535];

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Reference-model buffer indices (entries consumed per buffer).
    int m_xi = 0;
    int m_hi = 0;

    // Four 2-byte entries per buffer: address = base + 2*(idx mod 4).
    function automatic logic [15:0] maddr(input logic [15:0] base, input int idx);
        return base + 16'((idx % 4) * 2);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host_init;
        dag_we = 1'b1;
        dag_wsel = CBS_X;
        dag_wd = XCFG;
        tick;
        dag_wsel = CBS_H;
        dag_wd = HCFG;
        tick;
        dag_we = 1'b0;
        m_xi = 0;
        m_hi = 0;
    endtask

    task automatic load_mem(input logic [15:0] x0, x1, x2, x3,
                            input logic [15:0] h0, h1, h2, h3);
        mem[16'hAB00] = x0; mem[16'hAB02] = x1;
        mem[16'hAB04] = x2; mem[16'hAB06] = x3;
        mem[16'hC000] = h0; mem[16'hC002] = h1;
        mem[16'hC004] = h2; mem[16'hC006] = h3;
    endtask

    // One filter run: start in the current cycle, check every cycle.
    task automatic run(input int n, input int pulse_c, input string tag);
        logic [15:0]     xa[$];
        logic [15:0]     ha[$];
        longint          s;
        logic [ACCW-1:0] y_e;
        int              last;
        s = 0;
        for (int k = 0; k < n; k++) begin
            xa.push_back(maddr(16'hAB00, m_xi));
            ha.push_back(maddr(16'hC000, m_hi));
            m_xi++;
            m_hi++;
            s += longint'($signed(mem[xa[k]])) * longint'($signed(mem[ha[k]]));
        end
        y_e = s[ACCW-1:0];
        last = 5 * n + 1;
        taps = 8'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
        taps = 8'($urandom);
        for (int c = 1; c <= last; c++) begin
            logic            bz, dre_e, mrd_e, yv_e;
            logic [2:0]      cbs_e;
            logic [15:0]     addr_e;
            logic [ACCW-1:0] yc_e;
            int              p, k;
            p = (c - 1) % 5;
            k = (c - 1) / 5;
            bz = (c <= 5 * n);
            dre_e = bz && (p == 0 || p == 2);
            mrd_e = bz && (p == 1 || p == 3);
            cbs_e = (bz && p == 2) ? CBS_H : CBS_X;
            yv_e = (c == last);
            addr_e = 16'h0;
            if (mrd_e) addr_e = (p == 1) ? xa[k] : ha[k];
            yc_e = yv_e ? y_e : '0;
            checks++;
            if ({dag_re, dag_cbs, mem_rd, busy, y_valid} !==
                {dre_e, cbs_e, mrd_e, bz, yv_e}) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: got re=%b cbs=%0d rd=%b busy=%b yv=%b want re=%b cbs=%0d rd=%b busy=%b yv=%b",
                         tag, c, dag_re, dag_cbs, mem_rd, busy, y_valid,
                         dre_e, cbs_e, mrd_e, bz, yv_e);
            end
            checks++;
            if (mem_addr !== addr_e) begin
                errors++;
                $display("FAIL %s addr cycle %0d: got %h want %h", tag, c, mem_addr, addr_e);
            end
            checks++;
            if (y !== yc_e) begin
                errors++;
                $display("FAIL %s y cycle %0d: got %h want %h", tag, c, y, yc_e);
            end
            start = (c == pulse_c);
            if (c == pulse_c) taps = 8'($urandom);
            tick;
        end
        start = 1'b0;
        checks++;
        if (y !== y_e || y_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s hold: got y=%h yv=%b busy=%b want y=%h yv=0 busy=0",
                     tag, y, y_valid, busy, y_e);
        end
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++;
        if ({dag_re, dag_cbs, mem_rd, mem_addr, busy, y, y_valid} !==
            {1'b0, CBS_X, 1'b0, 16'h0, 1'b0, 40'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got re=%b cbs=%0d rd=%b addr=%h busy=%b y=%h yv=%b",
                     dag_re, dag_cbs, mem_rd, mem_addr, busy, y, y_valid);
        end
        checks++;
        if ({dag_re2, mem_rd2, busy2, y2, y_valid2} !== 35'h0) begin
            errors++;
            $display("FAIL reset_values2: got re=%b rd=%b busy=%b y=%h yv=%b",
                     dag_re2, mem_rd2, busy2, y2, y_valid2);
        end
        #4 reset = 1'b0;
        tick;
    endtask

    task automatic test_basic_sum;
        host_init;
        load_mem(16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd1, 16'd1);
        run(4, 0, "basic");
        checks++;
        if (y !== 40'd10) begin
            errors++;
            $display("FAIL basic_y: got %h want %h", y, 40'd10);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({dag_re, dag_cbs, mem_rd, mem_addr, busy, y, y_valid} !==
            {1'b0, CBS_X, 1'b0, 16'h0, 1'b0, 40'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_idle: got re=%b cbs=%0d rd=%b addr=%h busy=%b y=%h yv=%b",
                     dag_re, dag_cbs, mem_rd, mem_addr, busy, y, y_valid);
        end
        #1 reset = 1'b0;
        tick;
    endtask

    task automatic test_signed_product;
        host_init;
        load_mem(16'hFFFD, 16'd0, 16'd0, 16'd0, 16'h0002, 16'd0, 16'd0, 16'd0);
        run(1, 0, "signed");
        checks++;
        if (y !== 40'hFF_FFFF_FFFA) begin
            errors++;
            $display("FAIL signed_y: got %h want %h", y, 40'hFF_FFFF_FFFA);
        end
    endtask

    task automatic test_wrap_zero;
        host_init;
        load_mem(16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd1, 16'd1);
        run(5, 7, "wrap");
        checks++;
        if (y !== 40'd11) begin
            errors++;
            $display("FAIL wrap_y: got %h want %h", y, 40'd11);
        end
        run(0, 0, "zero_taps");
        checks++;
        if (y !== 40'd0) begin
            errors++;
            $display("FAIL zero_y: got %h want 0", y);
        end
    endtask

    task automatic test_overflow;
        int          vc, nre, nrd, nh, nb;
        logic [31:0] yv;
        logic [15:0] aor;
        vc = 0; nre = 0; nrd = 0; nh = 0; nb = 0;
        yv = '0; aor = '0;
        taps2 = 8'd3;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (y_valid2) begin
                vc = c;
                yv = y2;
            end
            nre += int'(dag_re2);
            nrd += int'(mem_rd2);
            nh  += int'(dag_cbs2 == CBS_H);
            nb  += int'(busy2);
            aor |= mem_addr2;
            tick;
        end
        checks++;
        if (yv !== 32'hC000_0000) begin
            errors++;
            $display("FAIL ovf_y: got %h want %h", yv, 32'hC000_0000);
        end
        checks++;
        if (vc != 16) begin
            errors++;
            $display("FAIL ovf_valid_cycle: got %0d want 16", vc);
        end
        checks++;
        if (nre != 6 || nrd != 6 || nh != 3 || nb != 15 || aor !== 16'h0) begin
            errors++;
            $display("FAIL ovf_ctl: got re=%0d rd=%0d h=%0d busy=%0d aor=%h want 6 6 3 15 0000",
                     nre, nrd, nh, nb, aor);
        end
    endtask

    task automatic test_reset_mid_run;
        host_init;
        load_mem(16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd1, 16'd1);
        taps = 8'd4;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'hC002) begin
            errors++;
            $display("FAIL midrun_hm: got rd=%b addr=%h want rd=1 addr=c002", mem_rd, mem_addr);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({dag_re, dag_cbs, mem_rd, mem_addr, busy, y, y_valid} !==
            {1'b0, CBS_X, 1'b0, 16'h0, 1'b0, 40'h0, 1'b0}) begin
            errors++;
            $display("FAIL midrun_reset: got re=%b cbs=%0d rd=%b addr=%h busy=%b y=%h yv=%b",
                     dag_re, dag_cbs, mem_rd, mem_addr, busy, y, y_valid);
        end
        #1 reset = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || dag_re !== 1'b0 || y !== 40'h0) begin
            errors++;
            $display("FAIL midrun_idle: got busy=%b re=%b y=%h want 0 0 0", busy, dag_re, y);
        end
        host_init;
        run(4, 0, "rerun");
        checks++;
        if (y !== 40'd10) begin
            errors++;
            $display("FAIL rerun_y: got %h want %h", y, 40'd10);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int n;
            host_init;
            load_mem(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            n = $urandom_range(1, 12);
            run(n, $urandom_range(1, 5 * n), "random");
        end
        host_init;
        load_mem(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        run(255, 600, "taps255");
    endtask

    task automatic test_back_to_back;
        host_init;
        load_mem(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        run(3, 0, "b2b_a");
        run(2, 4, "b2b_b");
        run(6, 0, "b2b_c");
    endtask

    initial begin
        test_reset;
        test_basic_sum;
        test_signed_product;
        test_wrap_zero;
        test_overflow;
        test_reset_mid_run;
        test_random;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
